pc_fetch_ctrl: RTL
==================

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000: fetch address loaded on reset.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 The block SHALL have port redirect_valid, input, 1: branch/jump taken this cycle.
REQ-005 The block SHALL have port redirect_base, input, 32: PC of the redirecting instruction.
REQ-006 The block SHALL have port redirect_offset, input, 32: halfword offset, applied shifted left by 1.
REQ-007 The block SHALL have port imem_req, output, 1: instruction-memory request.
REQ-008 The block SHALL have port imem_addr, output, 32: request address.
REQ-009 The block SHALL have port imem_ack, input, 1: memory returns imem_rdata this cycle.
REQ-010 The block SHALL have port imem_rdata, input, 32: fetched instruction.
REQ-011 The block SHALL have port instr_valid, output, 1: instr_out/instr_pc valid to decode.
REQ-012 The block SHALL have port instr_ready, input, 1: decode accepts the instruction.
REQ-013 The block SHALL have port instr_out, output, 32: held instruction.
REQ-014 The block SHALL have port instr_pc, output, 32: address of instr_out.
REQ-015 The block SHALL have port flush_cnt, output, 8: count of discarded fetches; saturates at 255.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH and HOLD; IDLE is entered only by reset and always moves to FETCH on the next edge.
REQ-017 imem_req SHALL be 1 exactly in FETCH, and imem_addr SHALL equal the internal pc register.
REQ-018 In FETCH, imem_addr SHALL stay stable from request assertion until the imem_ack cycle inclusive.
REQ-019 Redirect target SHALL be redirect_base + (redirect_offset << 1), truncated mod 2^32; there is no alignment check.
REQ-020 FETCH, ack, no redirect this cycle, no flush pending: latch instr_out=imem_rdata and instr_pc=pc, then go to HOLD; instr_valid=1 from the next cycle.
REQ-021 FETCH, redirect without ack: set flush_pending, store the target, and keep imem_addr unchanged.
REQ-022 A later redirect while flush_pending SHALL overwrite the stored target; the last one wins.
REQ-023 FETCH, ack with flush_pending or a redirect in the same cycle: discard rdata, set pc to the target (a same-cycle redirect beats the stored one), clear flush_pending, increment flush_cnt, and stay in FETCH with the new address next cycle.
REQ-024 HOLD, instr_ready=1, no redirect: pc<=pc+4 (wraps at 2^32), go to FETCH, instr_valid=0 next cycle.
REQ-025 HOLD, redirect (redirect beats instr_ready): pc<=target, go to FETCH, instr_valid=0 next cycle, increment flush_cnt.
REQ-026 HOLD, instr_ready=0, no redirect: hold all outputs stable.
REQ-027 imem_ack outside FETCH SHALL be ignored.
REQ-028 Redirect in IDLE SHALL be ignored.
REQ-029 Best-case throughput SHALL be one instruction per 2 cycles (FETCH+HOLD); ack latency is unbounded.

Reset
REQ-030 While rst=1, state SHALL be IDLE and pc SHALL be RESET_PC.
REQ-031 While rst=1, imem_req, instr_valid, instr_out, instr_pc, flush_pending and flush_cnt SHALL all be 0.
REQ-032 An rst assertion mid-fetch SHALL abandon the outstanding request with no replay.
REQ-033 The first request after rst deasserts SHALL be at RESET_PC, one cycle after IDLE.

Verification
REQ-034 Reset release, imem_ack same cycle as req, instr_ready=1 -> imem_addr 0x0,0x4,0x8 on alternating cycles; instr_pc matches.
REQ-035 Ack delayed 3 cycles -> imem_addr held at 0x4 for all 4 FETCH cycles; instr_out=rdata on ack.
REQ-036 Redirect base=0x100, offset=0x8 during HOLD with instr_ready=1 -> next imem_addr=0x110, instr_valid drops, flush_cnt=1.
REQ-037 Redirect (target 0x200) during pending fetch at 0x8, then ack 2 cycles later -> rdata discarded, instr_valid stays 0, next imem_addr=0x200.
REQ-038 pc=0xFFFF_FFFC accepted -> next imem_addr=0x0.
REQ-039 300 flushes -> flush_cnt=255.
REQ-040 rst pulsed while waiting on ack -> imem_req=0 immediately and the next request is at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_ctrl
// Description : Program-counter and instruction-fetch controller. It issues
//               one instruction-memory request at a time, holds the returned
//               instruction for decode until it is accepted, and handles
//               branch/jump redirects. A redirect that arrives while a fetch
//               is outstanding is remembered, and the wrong-path data is
//               discarded when its ack arrives.
// Ports       :
//   clk             - clock, all state changes on rising edge
//   rst             - asynchronous active-high reset
//   redirect_valid  - branch/jump taken this cycle
//   redirect_base   - PC of the redirecting instruction
//   redirect_offset - halfword offset (applied shifted left by 1)
//   imem_req        - instruction-memory request (high only in FETCH)
//   imem_addr       - request address (the pc register)
//   imem_ack        - imem_rdata valid this cycle
//   imem_rdata      - fetched instruction
//   instr_valid     - instr_out / instr_pc valid to decode
//   instr_ready     - decode accepts the instruction
//   instr_out       - held instruction
//   instr_pc        - address of instr_out
//   flush_cnt       - saturating count of discarded fetches
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_base,
    input  logic [31:0] redirect_offset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic [7:0]  flush_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam logic [7:0] c_CNT_MAX = 8'hFF;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_flush_pending;
    logic [31:0] r_target;
    logic [7:0]  r_flush_cnt;

    logic [31:0] w_target;
    logic        w_in_fetch;
    logic        w_in_hold;
    logic        w_flush_ack;
    logic        w_accept;
    logic        w_hold_redir;
    logic        w_hold_adv;
    logic        w_req;
    logic        w_valid;

    // Offset is in halfwords; the shift drops bit 31 and the sum wraps.
    assign w_target     = redirect_base + (redirect_offset << 1);

    assign w_in_fetch   = (r_state == S_FETCH);
    assign w_in_hold    = (r_state == S_HOLD);

    // Ack on the wrong path: either a redirect is already stored or one
    // arrives in the same cycle as the data.
    assign w_flush_ack  = w_in_fetch && imem_ack && (redirect_valid || r_flush_pending);
    assign w_accept     = w_in_fetch && imem_ack && !redirect_valid && !r_flush_pending;

    // In HOLD a redirect takes priority over decode accepting the instruction.
    assign w_hold_redir = w_in_hold && redirect_valid;
    assign w_hold_adv   = w_in_hold && !redirect_valid && instr_ready;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_FETCH;
            S_FETCH: if (w_accept) w_state_nxt = S_HOLD;
            S_HOLD:  if (redirect_valid || instr_ready) w_state_nxt = S_FETCH;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        w_req   = 1'b0;
        w_valid = 1'b0;
        case (r_state)
            S_FETCH: w_req   = 1'b1;
            S_HOLD:  w_valid = 1'b1;
            default: begin
                w_req   = 1'b0;
                w_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc            <= RESET_PC;
            r_instr         <= 32'h0;
            r_instr_pc      <= 32'h0;
            r_flush_pending <= 1'b0;
            r_target        <= 32'h0;
            r_flush_cnt     <= 8'h0;
        end else begin
            // pc only moves on a completed fetch or when leaving HOLD, so the
            // request address is stable for the whole outstanding fetch.
            if (w_flush_ack) begin
                r_pc <= redirect_valid ? w_target : r_target;
            end else if (w_hold_redir) begin
                r_pc <= w_target;
            end else if (w_hold_adv) begin
                r_pc <= r_pc + 32'd4;
            end

            if (w_accept) begin
                r_instr    <= imem_rdata;
                r_instr_pc <= r_pc;
            end

            // Pending redirect: the last one before the ack wins.
            if (w_in_fetch) begin
                if (imem_ack) begin
                    r_flush_pending <= 1'b0;
                end else if (redirect_valid) begin
                    r_flush_pending <= 1'b1;
                    r_target        <= w_target;
                end
            end

            if ((w_flush_ack || w_hold_redir) && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 8'd1;
            end
        end
    end

    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign instr_valid = w_valid;
    assign instr_out   = r_instr;
    assign instr_pc    = r_instr_pc;
    assign flush_cnt   = r_flush_cnt;

endmodule
`default_nettype wire
